seq_alu: RTL

- Parametrised, registered successor to the team's combinational 4-bit operator ALU.
- Keeps the same 3-bit opcode map.
- Adds valid/ready handshakes on input and output, generic operand width, a multi-cycle restoring divider and divide-by-zero reporting.
- Sits between an operand-issue stage and a result consumer that may apply backpressure.

---
 rtl/seq_alu_pkg.sv | 26 ++
 rtl/seq_alu_div.sv | 72 +++++++
 rtl/seq_alu.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode and FSM state encodings shared by seq_alu and its bench.
// Rev 1.0
`default_nettype none

package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_DIV  = 3'b010,
    OP_LAND = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_NAND = 3'b110,
    OP_XNOR = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_alu_div.sv
// seq_alu_div: iterative restoring divider, one quotient bit per cycle, WIDTH cycles.
// Rev 1.0
`default_nettype none

module seq_alu_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // Partial remainder stays below the divisor, so one extra bit covers the shift.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        quo_q <= dividend;
        rem_q <= '0;
        dvs_q <= divisor;
        cnt_q <= CNT_W'(WIDTH);
        busy  <= 1'b1;
      end else if (busy) begin
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_q <= diff[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= rem_sh[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// seq_alu: registered 8-op ALU with valid/ready handshakes and a multi-cycle divider.
// Optional remainder output enabled by SEQ_ALU_REM_EN. Rev 1.0
`default_nettype none

module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   y,
`ifdef SEQ_ALU_REM_EN
  output logic [WIDTH-1:0] rem,
`endif
  output logic             div_by_zero
);

  state_e           state;
  logic [WIDTH:0]   alu_res;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  always_comb begin
    alu_res = '0;
    case (sel)
      OP_ADD:  alu_res = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu_res = {1'b0, a} - {1'b0, b};
      OP_LAND: alu_res = {{WIDTH{1'b0}}, (a != '0) && (b != '0)};
      OP_AND:  alu_res = {1'b0, a & b};
      OP_OR:   alu_res = {1'b0, a | b};
      OP_NAND: alu_res = {1'b0, ~(a & b)};
      OP_XNOR: alu_res = {1'b0, ~(a ^ b)};
      default: alu_res = '0;
    endcase
  end

  assign div_start = (state == IDLE) && in_valid && (sel == OP_DIV) && (b != '0);

  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

`ifndef SEQ_ALU_REM_EN
  logic rem_unused;
  assign rem_unused = ^div_rem;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      y           <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_ALU_REM_EN
      rem         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (sel == OP_DIV && b != '0) begin
              state <= DIV;
            end else if (sel == OP_DIV) begin
              y           <= '1;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
`ifdef SEQ_ALU_REM_EN
              rem         <= a;
`endif
            end else begin
              y           <= alu_res;
              div_by_zero <= 1'b0;
              out_valid   <= 1'b1;
              state       <= DONE;
`ifdef SEQ_ALU_REM_EN
              rem         <= '0;
`endif
            end
          end
        end
        DIV: begin
          if (div_done && !div_busy) begin
            y         <= {1'b0, div_quo};
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SEQ_ALU_REM_EN
            rem       <= div_rem;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            in_ready    <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
